psum_drain: RTL and testbench



---
 rtl/psum_drain_pkg.sv | 20 ++
 rtl/psum_requant.sv | 50 +++++
 rtl/psum_drain.sv | 140 ++++++++++++++
 tb/tb_psum_drain.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_drain_pkg.sv
// rtl/psum_drain_pkg.sv - shared types, saturation bounds and width helper for the psum drain
package psum_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_QUANT = 3'd2,
        ST_OUT   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam int SAT_S_MIN = -128;
    localparam int SAT_S_MAX = 127;
    localparam int SAT_U_MAX = 255;

    function automatic int psum_width(input int col_width);
        return 2 * col_width;
    endfunction

endpackage

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - combinational requantizer: arithmetic shift, optional ReLU, 8-bit saturation
module psum_requant
    import psum_drain_pkg::*;
#(
    parameter int ACC_WIDTH = 32
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    input  logic [3:0]                  i_shift,
    input  logic                        i_signed_out,
    input  logic                        i_relu,
    output logic [7:0]                  o_data
);

    localparam logic signed [ACC_WIDTH-1:0] L_S_MIN = ACC_WIDTH'(SAT_S_MIN);
    localparam logic signed [ACC_WIDTH-1:0] L_S_MAX = ACC_WIDTH'(SAT_S_MAX);
    localparam logic signed [ACC_WIDTH-1:0] L_U_MAX = ACC_WIDTH'(SAT_U_MAX);

    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic signed [ACC_WIDTH-1:0] w_clamped;
    logic [7:0]                  w_sat;

    // Shift, clamp negatives when ReLU is on, then saturate against the full-width value
    always_comb begin
        w_shifted = i_acc >>> i_shift;
        w_clamped = w_shifted;
        if (i_relu && w_shifted[ACC_WIDTH-1]) begin
            w_clamped = '0;
        end
        if (i_signed_out) begin
            if (w_clamped < L_S_MIN) begin
                w_sat = L_S_MIN[7:0];
            end else if (w_clamped > L_S_MAX) begin
                w_sat = L_S_MAX[7:0];
            end else begin
                w_sat = w_clamped[7:0];
            end
        end else begin
            if (w_clamped[ACC_WIDTH-1]) begin
                w_sat = 8'd0;
            end else if (w_clamped > L_U_MAX) begin
                w_sat = L_U_MAX[7:0];
            end else begin
                w_sat = w_clamped[7:0];
            end
        end
    end

    assign o_data = w_sat;

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - column-bottom psum accumulator with requantized valid/ready output
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int COL_WIDTH = 11,
    parameter int ACC_WIDTH = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [7:0]                   i_cfg_passes,
    input  logic [15:0]                  i_cfg_outputs,
    input  logic [3:0]                   i_cfg_shift,
    input  logic                         i_cfg_signed_out,
    input  logic                         i_cfg_relu,
    input  logic                         i_psum_valid,
    input  logic [2*COL_WIDTH-1:0]       i_psum_in,
    output logic                         o_psum_ready,
    output logic                         o_out_valid,
    output logic [7:0]                   o_out_data,
    input  logic                         i_out_ready,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int PSUM_W = psum_width(COL_WIDTH);

    state_t                    r_state;
    state_t                    w_next;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [7:0]                r_pass_cnt;
    logic [15:0]               r_out_cnt;
    logic [7:0]                r_passes;
    logic [15:0]               r_outputs;
    logic [3:0]                r_shift;
    logic                      r_signed_out;
    logic                      r_relu;
    logic [7:0]                r_out_data;

    logic                      w_accept;
    logic                      w_last_pass;
    logic                      w_out_hs;
    logic                      w_last_out;
    logic [7:0]                w_quant;
    logic signed [ACC_WIDTH-1:0] w_psum_ext;

    assign w_accept    = i_psum_valid && (r_state == ST_ACCUM);
    assign w_last_pass = (r_pass_cnt == r_passes - 8'd1);
    assign w_out_hs    = i_out_ready && (r_state == ST_OUT);
    assign w_last_out  = (r_out_cnt == r_outputs - 16'd1);
    assign w_psum_ext  = {{(ACC_WIDTH-PSUM_W){i_psum_in[PSUM_W-1]}}, i_psum_in};

    psum_requant #(.ACC_WIDTH(ACC_WIDTH)) u_requant (
        .i_acc        (r_acc),
        .i_shift      (r_shift),
        .i_signed_out (r_signed_out),
        .i_relu       (r_relu),
        .o_data       (w_quant)
    );

    // State register; reset aborts any job without a done pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = (i_cfg_outputs == 16'd0) ? ST_FIN : ST_ACCUM;
            ST_ACCUM: if (w_accept && w_last_pass) w_next = ST_QUANT;
            ST_QUANT: w_next = ST_OUT;
            ST_OUT:   if (w_out_hs) w_next = w_last_out ? ST_FIN : ST_ACCUM;
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from the registered state
    always_comb begin
        o_psum_ready = (r_state == ST_ACCUM);
        o_out_valid  = (r_state == ST_OUT);
        o_busy       = (r_state != ST_IDLE);
        o_done       = (r_state == ST_FIN);
    end

    // Datapath: config latch, accumulation, requantized result capture and counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc        <= '0;
            r_pass_cnt   <= '0;
            r_out_cnt    <= '0;
            r_passes     <= 8'd1;
            r_outputs    <= '0;
            r_shift      <= '0;
            r_signed_out <= 1'b0;
            r_relu       <= 1'b0;
            r_out_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_passes     <= (i_cfg_passes == 8'd0) ? 8'd1 : i_cfg_passes;
                        r_outputs    <= i_cfg_outputs;
                        r_shift      <= i_cfg_shift;
                        r_signed_out <= i_cfg_signed_out;
                        r_relu       <= i_cfg_relu;
                        r_acc        <= '0;
                        r_pass_cnt   <= '0;
                        r_out_cnt    <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc      <= r_acc + w_psum_ext;
                        r_pass_cnt <= r_pass_cnt + 8'd1;
                    end
                end
                ST_QUANT: begin
                    r_out_data <= w_quant;
                    r_acc      <= '0;
                    r_pass_cnt <= '0;
                end
                ST_OUT: begin
                    if (w_out_hs) begin
                        r_out_cnt <= r_out_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out_data = r_out_data;

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - directed self-checking bench for psum_drain
module tb_psum_drain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_passes = '0;
    logic [15:0] cfg_outputs = '0;
    logic [3:0]  cfg_shift = '0;
    logic        cfg_signed_out = 1'b0;
    logic        cfg_relu = 1'b0;
    logic        psum_valid = 1'b0;
    logic [21:0] psum_in = '0;
    logic        psum_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psum_drain #(.COL_WIDTH(11), .ACC_WIDTH(32)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .i_cfg_passes     (cfg_passes),
        .i_cfg_outputs    (cfg_outputs),
        .i_cfg_shift      (cfg_shift),
        .i_cfg_signed_out (cfg_signed_out),
        .i_cfg_relu       (cfg_relu),
        .i_psum_valid     (psum_valid),
        .i_psum_in        (psum_in),
        .o_psum_ready     (psum_ready),
        .o_out_valid      (out_valid),
        .o_out_data       (out_data),
        .i_out_ready      (out_ready),
        .o_busy           (busy),
        .o_done           (done)
    );

    task automatic do_start(input int p, input int o, input int sh, input bit sg, input bit rl);
        @(negedge clk);
        start          = 1'b1;
        cfg_passes     = 8'(p);
        cfg_outputs    = 16'(o);
        cfg_shift      = 4'(sh);
        cfg_signed_out = sg;
        cfg_relu       = rl;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_psum(input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (psum_ready) begin
                psum_valid = 1'b1;
                psum_in    = 22'(v);
                @(negedge clk);
                psum_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic get_out(output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                d = out_data;
                ok = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL reset_psum_ready got %b want 0", psum_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_signed;
        int          ps [3] = '{5, -7, 300};
        logic [7:0]  ex [3] = '{8'h05, 8'hF9, 8'h7F};
        logic [7:0]  d;
        bit          ok;
        do_start(1, 3, 0, 1'b1, 1'b0);
        checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_start got %b want 1", psum_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        for (int k = 0; k < 3; k++) begin
            send_psum(ps[k], ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_send%0d timeout got %b want 1", k, ok); end
            if (k == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_quant_cycle out_valid got %b want 0", out_valid); end
            end
            get_out(d, ok);
            checks++; if (ok !== 1'b1 || d !== ex[k]) begin errors++; $display("FAIL basic_out%0d got %h (ok=%b) want %h", k, d, ok, ex[k]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_after_done done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_shift_unsigned;
        logic [7:0] d;
        bit         ok;
        bit         all_ok;
        do_start(4, 1, 2, 1'b0, 1'b0);
        all_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_psum(100, ok);
            all_ok &= ok;
        end
        get_out(d, ok);
        checks++; if (!all_ok || ok !== 1'b1 || d !== 8'd100) begin errors++; $display("FAIL shift_unsigned got %0d (ok=%b) want 100", d, ok && all_ok); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL shift_done got %b want 1", done); end
    endtask

    task automatic test_relu;
        logic [7:0] d;
        bit         ok1, ok2, ok3;
        do_start(2, 1, 0, 1'b1, 1'b1);
        send_psum(-50, ok1);
        send_psum(10, ok2);
        get_out(d, ok3);
        checks++; if (!(ok1 && ok2 && ok3) || d !== 8'h00) begin errors++; $display("FAIL relu_on got %h want 00", d); end
        @(negedge clk);
        do_start(2, 1, 0, 1'b1, 1'b0);
        send_psum(-50, ok1);
        send_psum(10, ok2);
        get_out(d, ok3);
        checks++; if (!(ok1 && ok2 && ok3) || d !== 8'hD8) begin errors++; $display("FAIL relu_off got %h want d8", d); end
        @(negedge clk);
    endtask

    task automatic test_unsigned_sat;
        logic [7:0] d;
        bit         ok1, ok2;
        do_start(1, 2, 0, 1'b0, 1'b0);
        send_psum(300, ok1);
        get_out(d, ok2);
        checks++; if (!(ok1 && ok2) || d !== 8'hFF) begin errors++; $display("FAIL usat_high got %h want ff", d); end
        send_psum(-5, ok1);
        get_out(d, ok2);
        checks++; if (!(ok1 && ok2) || d !== 8'h00) begin errors++; $display("FAIL usat_low got %h want 00", d); end
        @(negedge clk);
    endtask

    task automatic test_zero_passes;
        logic [7:0] d;
        bit         ok1, ok2;
        do_start(0, 1, 0, 1'b1, 1'b0);
        send_psum(42, ok1);
        get_out(d, ok2);
        checks++; if (!(ok1 && ok2) || d !== 8'd42) begin errors++; $display("FAIL zero_passes got %0d want 42", d); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_passes_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [7:0] d;
        bit         ok1, ok2;
        bit         seen;
        int         bad;
        do_start(1, 2, 0, 1'b1, 1'b0);
        send_psum(20, ok1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checks++; if (!ok1 || !seen) begin errors++; $display("FAIL bp_out_valid got %b want 1", seen); end
        bad = 0;
        psum_valid = 1'b1;
        psum_in    = 22'(99);
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'd20 || psum_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        psum_valid = 1'b0;
        checks++; if (bad != 0 || out_data !== 8'd20) begin errors++; $display("FAIL bp_hold got %0d bad cycles data=%0d want 0 bad data=20", bad, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send_psum(3, ok1);
        get_out(d, ok2);
        checks++; if (!(ok1 && ok2) || d !== 8'd3) begin errors++; $display("FAIL bp_no_consume got %0d want 3", d); end
        @(negedge clk);
    endtask

    task automatic test_zero_outputs;
        int cyc;
        bit seen_done;
        bit seen_valid;
        @(negedge clk);
        start       = 1'b1;
        cfg_passes  = 8'd1;
        cfg_outputs = 16'd0;
        seen_done   = 1'b0;
        seen_valid  = 1'b0;
        cyc         = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (out_valid) seen_valid = 1'b1;
            if (done && !seen_done) begin seen_done = 1'b1; cyc = i; end
            @(negedge clk);
        end
        checks++; if (!seen_done || cyc > 2) begin errors++; $display("FAIL zero_outputs_done got cycle %0d want 1..2", cyc); end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL zero_outputs_valid got %b want 0", seen_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_outputs_busy got %b want 0", busy); end
    endtask

    task automatic test_start_ignored;
        logic [7:0] d;
        bit         ok1, ok2;
        do_start(1, 1, 0, 1'b1, 1'b0);
        do_start(4, 5, 3, 1'b0, 1'b0);
        send_psum(6, ok1);
        get_out(d, ok2);
        checks++; if (!(ok1 && ok2) || d !== 8'd6) begin errors++; $display("FAIL start_ignored got %0d want 6", d); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL start_ignored_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [7:0] d;
        bit         ok1, ok2;
        bit         saw_done;
        do_start(4, 1, 0, 1'b1, 1'b0);
        send_psum(1000, ok1);
        send_psum(1000, ok2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        saw_done = done;
        checks++; if (busy !== 1'b0 || saw_done !== 1'b0 || psum_ready !== 1'b0) begin errors++; $display("FAIL abort_state busy=%b done=%b ready=%b want 0 0 0", busy, saw_done, psum_ready); end
        @(negedge clk);
        do_start(1, 1, 0, 1'b1, 1'b0);
        send_psum(9, ok1);
        get_out(d, ok2);
        checks++; if (!(ok1 && ok2) || d !== 8'd9) begin errors++; $display("FAIL abort_new_job got %0d want 9", d); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic_signed;
        test_shift_unsigned;
        test_relu;
        test_unsigned_sat;
        test_zero_passes;
        test_backpressure;
        test_zero_outputs;
        test_start_ignored;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
